// File: rtl/alu_reservation_station_if.sv
// Dispatch/CDB/ALU bundle for the ALU reservation station.
// The master side is dispatch plus the result buses; the slave side is the station.
interface alu_reservation_station_if #(
  parameter int TAG_W = 3,
  parameter int OP_W  = 5
);
  logic             flush;
  logic             issue_valid;
  logic             issue_ready;
  logic [OP_W-1:0]  issue_op;
  logic [31:0]      issue_vj;
  logic [31:0]      issue_vk;
  logic [TAG_W-1:0] issue_qj;
  logic [TAG_W-1:0] issue_qk;
  logic [TAG_W-1:0] issue_des;
  logic             issue_is_branch;
  logic [TAG_W-1:0] alu_cdb_tag;
  logic [31:0]      alu_cdb_value;
  logic [TAG_W-1:0] lsb_cdb_tag;
  logic [31:0]      lsb_cdb_value;
  logic [31:0]      alu_value_1;
  logic [31:0]      alu_value_2;
  logic [OP_W-1:0]  alu_op;
  logic [TAG_W-1:0] alu_des;
  logic             alu_is_branch;

  modport master (
    output flush, issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
           issue_des, issue_is_branch, alu_cdb_tag, alu_cdb_value, lsb_cdb_tag,
           lsb_cdb_value,
    input  issue_ready, alu_value_1, alu_value_2, alu_op, alu_des, alu_is_branch
  );

  modport slave (
    input  flush, issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
           issue_des, issue_is_branch, alu_cdb_tag, alu_cdb_value, lsb_cdb_tag,
           lsb_cdb_value,
    output issue_ready, alu_value_1, alu_value_2, alu_op, alu_des, alu_is_branch
  );
endinterface

// File: rtl/alu_reservation_station.sv
// Integer ALU reservation station: buffers dispatched ops, snoops the ALU and
// load result buses for missing operands, and sends the lowest-index ready op
// to the ALU each cycle on registered outputs. Tag 0 means "no tag / no op".
module alu_reservation_station #(
  parameter int RS_SIZE = 4,
  parameter int TAG_W   = 3,
  parameter int OP_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_reservation_station_if.slave rs
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] rdy;
  logic [OP_W-1:0]    op_r  [RS_SIZE];
  logic [31:0]        vj_r  [RS_SIZE];
  logic [31:0]        vk_r  [RS_SIZE];
  logic [TAG_W-1:0]   qj_r  [RS_SIZE];
  logic [TAG_W-1:0]   qk_r  [RS_SIZE];
  logic [TAG_W-1:0]   des_r [RS_SIZE];
  logic               br_r  [RS_SIZE];

  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               alloc;
  logic               sel_fire;
  logic [TAG_W-1:0]   fwd_qj;
  logic [TAG_W-1:0]   fwd_qk;
  logic [31:0]        fwd_vj;
  logic [31:0]        fwd_vk;

  // Operand capture from the result buses; the ALU bus wins if both match.
  function automatic logic [TAG_W+31:0] snoop(
    input logic [TAG_W-1:0] q,
    input logic [31:0]      v,
    input logic [TAG_W-1:0] a_tag,
    input logic [31:0]      a_val,
    input logic [TAG_W-1:0] l_tag,
    input logic [31:0]      l_val
  );
    if (q != '0 && q == a_tag)      snoop = {{TAG_W{1'b0}}, a_val};
    else if (q != '0 && q == l_tag) snoop = {{TAG_W{1'b0}}, l_val};
    else                            snoop = {q, v};
  endfunction

  assign rs.issue_ready = ~(&busy);
  assign alloc    = rs.issue_valid && rs.issue_ready && !rs.flush;
  assign sel_fire = (|rdy) && !rs.flush;

  // Ready vector, lowest free / lowest ready slot, and alloc-time forwarding.
  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    for (int i = 0; i < RS_SIZE; i++)
      rdy[i] = busy[i] && (qj_r[i] == '0) && (qk_r[i] == '0);
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
      if (rdy[i])   sel_idx  = IDX_W'(i);
    end
    {fwd_qj, fwd_vj} = snoop(rs.issue_qj, rs.issue_vj, rs.alu_cdb_tag, rs.alu_cdb_value,
                             rs.lsb_cdb_tag, rs.lsb_cdb_value);
    {fwd_qk, fwd_vk} = snoop(rs.issue_qk, rs.issue_vk, rs.alu_cdb_tag, rs.alu_cdb_value,
                             rs.lsb_cdb_tag, rs.lsb_cdb_value);
  end

  // Busy bits: flush clears all; select frees one slot while alloc fills another.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (rs.flush) begin
      busy <= '0;
    end else begin
      if (sel_fire) busy[sel_idx]  <= 1'b0;
      if (alloc)    busy[free_idx] <= 1'b1;
    end
  end

  // Entry payload: wakeup on busy entries, overwritten by a new allocation.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy[i]) begin
        {qj_r[i], vj_r[i]} <= snoop(qj_r[i], vj_r[i], rs.alu_cdb_tag, rs.alu_cdb_value,
                                    rs.lsb_cdb_tag, rs.lsb_cdb_value);
        {qk_r[i], vk_r[i]} <= snoop(qk_r[i], vk_r[i], rs.alu_cdb_tag, rs.alu_cdb_value,
                                    rs.lsb_cdb_tag, rs.lsb_cdb_value);
      end
      if (alloc && free_idx == IDX_W'(i)) begin
        op_r[i]  <= rs.issue_op;
        vj_r[i]  <= fwd_vj;
        vk_r[i]  <= fwd_vk;
        qj_r[i]  <= fwd_qj;
        qk_r[i]  <= fwd_qk;
        des_r[i] <= rs.issue_des;
        br_r[i]  <= rs.issue_is_branch;
      end
    end
  end

  // Registered ALU outputs; bubbles zero the control fields but keep operand values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs.alu_value_1   <= '0;
      rs.alu_value_2   <= '0;
      rs.alu_op        <= '0;
      rs.alu_des       <= '0;
      rs.alu_is_branch <= 1'b0;
    end else if (sel_fire) begin
      rs.alu_value_1   <= vj_r[sel_idx];
      rs.alu_value_2   <= vk_r[sel_idx];
      rs.alu_op        <= op_r[sel_idx];
      rs.alu_des       <= des_r[sel_idx];
      rs.alu_is_branch <= br_r[sel_idx];
    end else begin
      rs.alu_op        <= '0;
      rs.alu_des       <= '0;
      rs.alu_is_branch <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed vectors, expected dispatches
// queued by the stimulus and checked by an independent output monitor.
module tb_alu_reservation_station;
  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_reservation_station_if #(.TAG_W(3), .OP_W(5)) ifc ();

  alu_reservation_station #(.RS_SIZE(4), .TAG_W(3), .OP_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .rs (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [2:0]  des;
    logic        br;
  } disp_t;

  disp_t exp_q[$];
  int    n_total = 0;
  int    n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [4:0] op, input logic [31:0] vj, input logic [2:0] qj,
                           input logic [31:0] vk, input logic [2:0] qk, input logic [2:0] des,
                           input logic br);
    ifc.issue_valid     = 1'b1;
    ifc.issue_op        = op;
    ifc.issue_vj        = vj;
    ifc.issue_qj        = qj;
    ifc.issue_vk        = vk;
    ifc.issue_qk        = qk;
    ifc.issue_des       = des;
    ifc.issue_is_branch = br;
  endtask

  task automatic push(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [2:0] des, input logic br);
    disp_t d;
    d.op = op; d.v1 = v1; d.v2 = v2; d.des = des; d.br = br;
    exp_q.push_back(d);
  endtask

  // Monitor: every non-bubble dispatch must match the oldest queued expectation.
  always @(negedge clk) begin
    disp_t got;
    if (!rst && ifc.alu_des != 3'd0) begin
      got = {ifc.alu_op, ifc.alu_value_1, ifc.alu_value_2, ifc.alu_des, ifc.alu_is_branch};
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_dispatch got op=%0d v1=%h v2=%h des=%0d br=%0b required no dispatch",
                 got.op, got.v1, got.v2, got.des, got.br);
      end else begin
        disp_t e;
        e = exp_q.pop_front();
        if (got === e) n_pass++;
        else $display("FAIL dispatch got op=%0d v1=%h v2=%h des=%0d br=%0b required op=%0d v1=%h v2=%h des=%0d br=%0b",
                      got.op, got.v1, got.v2, got.des, got.br, e.op, e.v1, e.v2, e.des, e.br);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    ifc.flush = 1'b0; ifc.issue_valid = 1'b0; ifc.issue_op = '0;
    ifc.issue_vj = '0; ifc.issue_vk = '0; ifc.issue_qj = '0; ifc.issue_qk = '0;
    ifc.issue_des = '0; ifc.issue_is_branch = 1'b0;
    ifc.alu_cdb_tag = '0; ifc.alu_cdb_value = '0; ifc.lsb_cdb_tag = '0; ifc.lsb_cdb_value = '0;
    #12;
    chk("reset_des", 32'(ifc.alu_des), 32'd0);
    chk("reset_op", 32'(ifc.alu_op), 32'd0);
    chk("reset_v1", ifc.alu_value_1, 32'd0);
    chk("reset_v2", ifc.alu_value_2, 32'd0);
    chk("reset_ready", 32'(ifc.issue_ready), 32'd1);
    cyc();
    rst = 1'b0;
    cyc();

    // Ready op: one edge to allocate, next edge to dispatch, then a bubble.
    set_issue(5'd0, 32'd5, 3'd0, 32'd7, 3'd0, 3'd3, 1'b0);
    push(5'd0, 32'd5, 32'd7, 3'd3, 1'b0);
    cyc();
    ifc.issue_valid = 1'b0;
    chk("t1_no_bypass", 32'(ifc.alu_des), 32'd0);
    cyc();
    chk("t1_des", 32'(ifc.alu_des), 32'd3);
    chk("t1_v1", ifc.alu_value_1, 32'd5);
    cyc();
    chk("t1_bubble", 32'(ifc.alu_des), 32'd0);
    chk("t1_v1_hold", ifc.alu_value_1, 32'd5);

    // Waiting on tag 2, woken by the ALU bus two cycles later.
    set_issue(5'd1, 32'd0, 3'd2, 32'd1, 3'd0, 3'd4, 1'b0);
    push(5'd1, 32'd10, 32'd1, 3'd4, 1'b0);
    cyc();
    ifc.issue_valid = 1'b0;
    cyc();
    chk("t2_wait", 32'(ifc.alu_des), 32'd0);
    ifc.alu_cdb_tag = 3'd2; ifc.alu_cdb_value = 32'd10;
    cyc();
    ifc.alu_cdb_tag = 3'd0; ifc.alu_cdb_value = 32'd0;
    chk("t2_wake_not_yet", 32'(ifc.alu_des), 32'd0);
    cyc();
    chk("t2_des", 32'(ifc.alu_des), 32'd4);
    chk("t2_v1", ifc.alu_value_1, 32'd10);

    // Load bus forwards qk during allocation; branch flag passes through.
    set_issue(5'd2, 32'd3, 3'd0, 32'd0, 3'd5, 3'd5, 1'b1);
    ifc.lsb_cdb_tag = 3'd5; ifc.lsb_cdb_value = 32'hFFFF_FFFF;
    push(5'd2, 32'd3, 32'hFFFF_FFFF, 3'd5, 1'b1);
    cyc();
    ifc.issue_valid = 1'b0;
    ifc.lsb_cdb_tag = 3'd0; ifc.lsb_cdb_value = 32'd0;
    cyc();
    chk("t3_des", 32'(ifc.alu_des), 32'd5);
    chk("t3_v2", ifc.alu_value_2, 32'hFFFF_FFFF);
    chk("t3_br", 32'(ifc.alu_is_branch), 32'd1);

    // Fill all slots waiting on tag 6; a fifth issue is ignored.
    for (int i = 0; i < 4; i++) begin
      set_issue(5'd3, 32'd0, 3'd6, 32'(i + 1), 3'd0, 3'(i + 1), 1'b0);
      cyc();
    end
    chk("t4_full", 32'(ifc.issue_ready), 32'd0);
    set_issue(5'd9, 32'd1, 3'd0, 32'd1, 3'd0, 3'd7, 1'b0);
    cyc();
    ifc.issue_valid = 1'b0;
    chk("t4_still_full", 32'(ifc.issue_ready), 32'd0);
    chk("t4_no_dispatch", 32'(ifc.alu_des), 32'd0);
    ifc.alu_cdb_tag = 3'd6; ifc.alu_cdb_value = 32'd100;
    for (int i = 0; i < 4; i++) push(5'd3, 32'd100, 32'(i + 1), 3'(i + 1), 1'b0);
    cyc();
    ifc.alu_cdb_tag = 3'd0; ifc.alu_cdb_value = 32'd0;
    chk("t4_ready_after_wake", 32'(ifc.issue_ready), 32'd0);
    cyc();
    chk("t4_first_des", 32'(ifc.alu_des), 32'd1);
    chk("t4_ready_after_first", 32'(ifc.issue_ready), 32'd1);
    cyc(); cyc(); cyc();
    chk("t4_last_des", 32'(ifc.alu_des), 32'd4);
    cyc();
    chk("t4_bubble", 32'(ifc.alu_des), 32'd0);

    // Flush with two ready entries and a same-cycle issue: nothing survives.
    set_issue(5'd4, 32'd1, 3'd7, 32'd2, 3'd0, 3'd1, 1'b0);
    cyc();
    set_issue(5'd4, 32'd3, 3'd7, 32'd4, 3'd0, 3'd2, 1'b0);
    cyc();
    ifc.issue_valid = 1'b0;
    ifc.alu_cdb_tag = 3'd7; ifc.alu_cdb_value = 32'd9;
    cyc();
    ifc.alu_cdb_tag = 3'd0; ifc.alu_cdb_value = 32'd0;
    ifc.flush = 1'b1;
    set_issue(5'd5, 32'd1, 3'd0, 32'd1, 3'd0, 3'd3, 1'b0);
    cyc();
    ifc.flush = 1'b0;
    ifc.issue_valid = 1'b0;
    chk("t5_des", 32'(ifc.alu_des), 32'd0);
    chk("t5_ready", 32'(ifc.issue_ready), 32'd1);
    repeat (4) cyc();
    chk("t5_after", 32'(ifc.alu_des), 32'd0);

    // Asynchronous reset between edges while an op is on the outputs.
    set_issue(5'd6, 32'd0, 3'd4, 32'd0, 3'd0, 3'd6, 1'b0);
    cyc();
    set_issue(5'd6, 32'd11, 3'd0, 32'd12, 3'd0, 3'd3, 1'b0);
    cyc();
    ifc.issue_valid = 1'b0;
    cyc();
    chk("t6_pre_des", 32'(ifc.alu_des), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_des", 32'(ifc.alu_des), 32'd0);
    chk("t6_rst_v1", ifc.alu_value_1, 32'd0);
    chk("t6_rst_ready", 32'(ifc.issue_ready), 32'd1);
    #10 rst = 1'b0;
    cyc();
    ifc.alu_cdb_tag = 3'd4; ifc.alu_cdb_value = 32'd5;
    cyc();
    ifc.alu_cdb_tag = 3'd0; ifc.alu_cdb_value = 32'd0;
    repeat (3) cyc();
    chk("t6_empty", 32'(ifc.alu_des), 32'd0);

    repeat (2) cyc();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
